lstm_gate_scheduler: RTL and testbench

- Sequences the shared fixed-point MAC array of the RNN layer through the NGATE gate matrix-vector products of one LSTM timestep (input, forget, output, candidate).
- Per gate: clears the accumulators, streams column addresses to the weight and input-vector memories, drains the MAC pipeline, then hands the result row downstream with a valid/ready handshake.
- Sits between the layer top-level controller (start/done) and the MAC datapath plus its weight/vector memories.

---
 rtl/rnn_pkg.sv | 41 ++++
 rtl/lstm_gate_scheduler_mac_addr_gen.sv | 79 +++++++
 rtl/lstm_gate_scheduler.sv | 177 +++++++++++++++++
 tb/tb_lstm_gate_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// -----------------------------------------------------------------------------
// rnn_pkg
// Shared definitions for the RNN layer control blocks.
//   state_e      : scheduler FSM state encoding (IDLE..DONE = 0..5)
//   GATE_*       : gate matrix indices in processing order (i, f, o, c)
//   clog2 / max2 : integer helpers for deriving port and counter widths
// -----------------------------------------------------------------------------
package rnn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int GATE_I = 0;
  localparam int GATE_F = 1;
  localparam int GATE_O = 2;
  localparam int GATE_C = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lstm_gate_scheduler_mac_addr_gen.sv
// -----------------------------------------------------------------------------
// mac_addr_gen
// Column / gate counters for the gate scheduler and the derived memory
// addresses. The FSM in the parent decides when to clear or advance.
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : zero both counters (has priority over advancing)
//   col_adv_i    : step the column counter, wrapping NCOL-1 -> 0
//   gate_adv_i   : step the gate counter, wrapping NGATE-1 -> 0
//   col_o/gate_o : current counter values
//   last_col_o   : column counter is at NCOL-1
//   last_gate_o  : gate counter is at NGATE-1
//   x_addr_o     : input-vector element index (= col)
//   w_addr_o     : weight row address (= gate*NCOL + col)
// -----------------------------------------------------------------------------
module mac_addr_gen
  import rnn_pkg::*;
#(
  parameter int NCOL    = 16,
  parameter int NGATE   = 4,
  parameter int COL_W   = clog2(NCOL),
  parameter int GATE_W  = max2(1, clog2(NGATE)),
  parameter int WADDR_W = clog2(NGATE * NCOL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               col_adv_i,
  input  logic               gate_adv_i,
  output logic [COL_W-1:0]   col_o,
  output logic [GATE_W-1:0]  gate_o,
  output logic               last_col_o,
  output logic               last_gate_o,
  output logic [COL_W-1:0]   x_addr_o,
  output logic [WADDR_W-1:0] w_addr_o
);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              last_col;
  logic              last_gate;

  assign last_col  = (col_q == COL_W'(NCOL - 1));
  assign last_gate = (gate_q == GATE_W'(NGATE - 1));

  always_comb begin
    col_d  = col_q;
    gate_d = gate_q;
    if (clr_i) begin
      col_d  = '0;
      gate_d = '0;
    end else begin
      if (col_adv_i) begin
        col_d = last_col ? '0 : col_q + COL_W'(1);
      end
      if (gate_adv_i) begin
        gate_d = last_gate ? '0 : gate_q + GATE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      gate_q <= '0;
    end else begin
      col_q  <= col_d;
      gate_q <= gate_d;
    end
  end

  assign col_o       = col_q;
  assign gate_o      = gate_q;
  assign last_col_o  = last_col;
  assign last_gate_o = last_gate;
  assign x_addr_o    = col_q;
  // Both counters stay in range, so the sum never exceeds NGATE*NCOL-1.
  assign w_addr_o    = WADDR_W'(gate_q) * WADDR_W'(NCOL) + WADDR_W'(col_q);

endmodule

// File: rtl/lstm_gate_scheduler.sv
// -----------------------------------------------------------------------------
// lstm_gate_scheduler
// Steps the shared MAC array through the NGATE gate matrix-vector products of
// one LSTM timestep: clear accumulators, stream NCOL columns, drain the MAC
// pipeline, then present the finished row downstream with valid/ready.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a timestep (only looked at in IDLE)
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse after the last gate result is accepted
//   src_valid   : input-vector element at x_addr is available
//   x_addr      : input-vector element index
//   w_addr      : weight row address = gate*NCOL + col
//   acc_clr     : zero all MAC accumulators
//   mac_en      : accumulate weight row x vector element this cycle
//   res_valid   : accumulators hold the finished gate result
//   res_gate    : gate index of the presented result
//   res_ready   : downstream accepts the result
// -----------------------------------------------------------------------------
module lstm_gate_scheduler
  import rnn_pkg::*;
#(
  parameter int NROW    = 16,
  parameter int NCOL    = 16,
  parameter int NGATE   = 4,
  parameter int MAC_LAT = 2,
  parameter int COL_W   = clog2(NCOL),
  parameter int GATE_W  = max2(1, clog2(NGATE)),
  parameter int WADDR_W = clog2(NGATE * NCOL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               src_valid,
  output logic [COL_W-1:0]   x_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               acc_clr,
  output logic               mac_en,
  output logic               res_valid,
  output logic [GATE_W-1:0]  res_gate,
  input  logic               res_ready
);

  localparam int DRAIN_W = max2(1, clog2(MAC_LAT));

  // Elaboration-time parameter sanity checks.
  if (NROW < 1) begin : g_bad_nrow
    $error("lstm_gate_scheduler: NROW must be >= 1");
  end
  if (NCOL < 2) begin : g_bad_ncol
    $error("lstm_gate_scheduler: NCOL must be >= 2");
  end
  if (NGATE < 1) begin : g_bad_ngate
    $error("lstm_gate_scheduler: NGATE must be >= 1");
  end
  if (MAC_LAT < 1) begin : g_bad_mac_lat
    $error("lstm_gate_scheduler: MAC_LAT must be >= 1");
  end

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic               ctr_clr;
  logic               col_adv;
  logic               gate_adv;
  logic [COL_W-1:0]   col_cur;
  logic [GATE_W-1:0]  gate_cur;
  logic               last_col;
  logic               last_gate;

  mac_addr_gen #(
    .NCOL    (NCOL),
    .NGATE   (NGATE),
    .COL_W   (COL_W),
    .GATE_W  (GATE_W),
    .WADDR_W (WADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (ctr_clr),
    .col_adv_i   (col_adv),
    .gate_adv_i  (gate_adv),
    .col_o       (col_cur),
    .gate_o      (gate_cur),
    .last_col_o  (last_col),
    .last_gate_o (last_gate),
    .x_addr_o    (x_addr),
    .w_addr_o    (w_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    busy      = 1'b1;
    done      = 1'b0;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    res_valid = 1'b0;
    ctr_clr   = 1'b0;
    col_adv   = 1'b0;
    gate_adv  = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ctr_clr = 1'b1;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        acc_clr = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        // Only combinational input->output path: a column is consumed
        // exactly when the vector element is present.
        mac_en = src_valid;
        if (src_valid) begin
          col_adv = 1'b1;
          if (last_col) begin
            drain_d = DRAIN_W'(MAC_LAT - 1);
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Counts MAC_LAT-1 down to 0, i.e. MAC_LAT idle cycles in total.
        if (drain_q == '0) begin
          state_d = WRITE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end

      WRITE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (last_gate) begin
            // Zero the counters so addresses read 0 in DONE and IDLE.
            ctr_clr = 1'b1;
            state_d = DONE;
          end else begin
            gate_adv = 1'b1;
            state_d  = CLEAR;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res_gate = (state_q == WRITE) ? gate_cur : '0;

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lstm_gate_scheduler
// Directed bench: one default-parameter scheduler driven through nominal,
// stall, backpressure, reset-abort and ignored-start timesteps using a table
// of per-cycle checkpoints, plus a small-parameter instance with start held.
// -----------------------------------------------------------------------------
module tb_lstm_gate_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (NCOL=16, NGATE=4, MAC_LAT=2)
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       src_valid;
  logic [3:0] x_addr;
  logic [5:0] w_addr;
  logic       acc_clr;
  logic       mac_en;
  logic       res_valid;
  logic [1:0] res_gate;
  logic       res_ready;

  // Small instance (NCOL=2, NGATE=1, MAC_LAT=1)
  logic       s_start;
  logic       s_busy;
  logic       s_done;
  logic       s_src_valid;
  logic [0:0] s_x_addr;
  logic [0:0] s_w_addr;
  logic       s_acc_clr;
  logic       s_mac_en;
  logic       s_res_valid;
  logic [0:0] s_res_gate;
  logic       s_res_ready;

  lstm_gate_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .src_valid (src_valid),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .acc_clr   (acc_clr),
    .mac_en    (mac_en),
    .res_valid (res_valid),
    .res_gate  (res_gate),
    .res_ready (res_ready)
  );

  lstm_gate_scheduler #(
    .NROW    (4),
    .NCOL    (2),
    .NGATE   (1),
    .MAC_LAT (1)
  ) dut_s (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .busy      (s_busy),
    .done      (s_done),
    .src_valid (s_src_valid),
    .x_addr    (s_x_addr),
    .w_addr    (s_w_addr),
    .acc_clr   (s_acc_clr),
    .mac_en    (s_mac_en),
    .res_valid (s_res_valid),
    .res_gate  (s_res_gate),
    .res_ready (s_res_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle checkpoint: {busy,done,res_valid,res_gate,acc_clr,mac_en,x,w}
  typedef struct {
    int         scen;
    int         cyc;
    logic       b;
    logic       d;
    logic       rv;
    logic [1:0] rg;
    logic       cl;
    logic       mc;
    logic [3:0] x;
    logic [5:0] w;
  } vec_t;

  typedef struct {
    int id;
    int done_k;
    int mac_cnt;
    int busy_cnt;
    int rv_cnt;
  } sc_t;

  vec_t vecs[$];

  task automatic v(input int s, input int c, input logic b, input logic d, input logic rv,
                   input logic [1:0] rg, input logic cl, input logic mc,
                   input logic [3:0] x, input logic [5:0] w);
    vec_t e;
    e.scen = s; e.cyc = c; e.b = b; e.d = d; e.rv = rv; e.rg = rg;
    e.cl = cl; e.mc = mc; e.x = x; e.w = w;
    vecs.push_back(e);
  endtask

  function automatic logic [16:0] pack_dut();
    return {busy, done, res_valid, res_gate, acc_clr, mac_en, x_addr, w_addr};
  endfunction

  function automatic logic [16:0] pack_vec(input vec_t e);
    return {e.b, e.d, e.rv, e.rg, e.cl, e.mc, e.x, e.w};
  endfunction

  // Scenario ids: 1 nominal, 2 src stall, 3 backpressure, 4 reset abort,
  // 5 nominal with a stray start pulse at cycle 10.
  task automatic run_scen(input sc_t sc);
    int first_done;
    int n_done;
    int n_mac;
    int n_busy;
    int n_rv;
    int n_ovl;
    int wexp;
    int werr;
    first_done = -1; n_done = 0; n_mac = 0; n_busy = 0; n_rv = 0;
    n_ovl = 0; wexp = 0; werr = 0;
    for (int k = 0; k <= 100; k++) begin
      start     = (k == 0) || (sc.id == 5 && k == 10);
      src_valid = !(sc.id == 2 && k >= 29 && k <= 33);
      res_ready = !(sc.id == 3 && k >= 60 && k <= 62);
      reset     = (sc.id == 4 && k == 30);
      #1;
      if (k >= 1) begin
        if (done) begin
          n_done++;
          if (first_done < 0) first_done = k;
        end
        if (mac_en) begin
          if (w_addr !== wexp[5:0] || x_addr !== wexp[3:0]) werr++;
          wexp++;
          n_mac++;
        end
        if (busy) n_busy++;
        if (res_valid) n_rv++;
        if (acc_clr && mac_en) n_ovl++;
        foreach (vecs[i]) begin
          if (vecs[i].scen == sc.id && vecs[i].cyc == k) begin
            chk($sformatf("s%0d_cyc%0d", sc.id, k), 32'(pack_dut()), 32'(pack_vec(vecs[i])));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    chk($sformatf("s%0d_done_cycle", sc.id), first_done, sc.done_k);
    chk($sformatf("s%0d_done_count", sc.id), n_done, (sc.done_k < 0) ? 0 : 1);
    chk($sformatf("s%0d_mac_count", sc.id), n_mac, sc.mac_cnt);
    chk($sformatf("s%0d_busy_count", sc.id), n_busy, sc.busy_cnt);
    chk($sformatf("s%0d_rv_count", sc.id), n_rv, sc.rv_cnt);
    chk($sformatf("s%0d_clr_mac_overlap", sc.id), n_ovl, 0);
    chk($sformatf("s%0d_addr_seq_err", sc.id), werr, 0);
    $display("scenario %0d: done at cycle %0d, mac_en cycles %0d", sc.id, first_done, n_mac);
  endtask

  sc_t scens[6];
  logic [6:0] s_exp[1:9];

  initial begin
    // Nominal timeline checkpoints
    v(1,  1, 1,0,0,2'd0, 1,0, 4'd0,  6'd0);
    v(1,  2, 1,0,0,2'd0, 0,1, 4'd0,  6'd0);
    v(1, 10, 1,0,0,2'd0, 0,1, 4'd8,  6'd8);
    v(1, 17, 1,0,0,2'd0, 0,1, 4'd15, 6'd15);
    v(1, 18, 1,0,0,2'd0, 0,0, 4'd0,  6'd0);
    v(1, 19, 1,0,0,2'd0, 0,0, 4'd0,  6'd0);
    v(1, 20, 1,0,1,2'd0, 0,0, 4'd0,  6'd0);
    v(1, 21, 1,0,0,2'd0, 1,0, 4'd0,  6'd16);
    v(1, 22, 1,0,0,2'd0, 0,1, 4'd0,  6'd16);
    v(1, 37, 1,0,0,2'd0, 0,1, 4'd15, 6'd31);
    v(1, 40, 1,0,1,2'd1, 0,0, 4'd0,  6'd16);
    v(1, 60, 1,0,1,2'd2, 0,0, 4'd0,  6'd32);
    v(1, 79, 1,0,0,2'd0, 0,0, 4'd0,  6'd48);
    v(1, 80, 1,0,1,2'd3, 0,0, 4'd0,  6'd48);
    v(1, 81, 1,1,0,2'd0, 0,0, 4'd0,  6'd0);
    v(1, 82, 0,0,0,2'd0, 0,0, 4'd0,  6'd0);
    // The stray start at cycle 10 must leave the nominal timeline untouched
    foreach (vecs[i]) begin
      if (vecs[i].scen == 1) begin
        vec_t e;
        e = vecs[i];
        e.scen = 5;
        vecs.push_back(e);
      end
    end
    // Stall at gate 1, column 7
    v(2, 28, 1,0,0,2'd0, 0,1, 4'd6,  6'd22);
    v(2, 29, 1,0,0,2'd0, 0,0, 4'd7,  6'd23);
    v(2, 31, 1,0,0,2'd0, 0,0, 4'd7,  6'd23);
    v(2, 33, 1,0,0,2'd0, 0,0, 4'd7,  6'd23);
    v(2, 34, 1,0,0,2'd0, 0,1, 4'd7,  6'd23);
    v(2, 35, 1,0,0,2'd0, 0,1, 4'd8,  6'd24);
    v(2, 45, 1,0,1,2'd1, 0,0, 4'd0,  6'd16);
    v(2, 86, 1,1,0,2'd0, 0,0, 4'd0,  6'd0);
    // Backpressure on gate 2 result
    v(3, 60, 1,0,1,2'd2, 0,0, 4'd0,  6'd32);
    v(3, 61, 1,0,1,2'd2, 0,0, 4'd0,  6'd32);
    v(3, 62, 1,0,1,2'd2, 0,0, 4'd0,  6'd32);
    v(3, 63, 1,0,1,2'd2, 0,0, 4'd0,  6'd32);
    v(3, 64, 1,0,0,2'd0, 1,0, 4'd0,  6'd48);
    v(3, 83, 1,0,1,2'd3, 0,0, 4'd0,  6'd48);
    v(3, 84, 1,1,0,2'd0, 0,0, 4'd0,  6'd0);
    // Reset during gate 1 ISSUE
    v(4, 30, 1,0,0,2'd0, 0,1, 4'd8,  6'd24);
    v(4, 31, 0,0,0,2'd0, 0,0, 4'd0,  6'd0);
    v(4, 32, 0,0,0,2'd0, 0,0, 4'd0,  6'd0);
    v(4, 60, 0,0,0,2'd0, 0,0, 4'd0,  6'd0);

    scens[0] = '{id: 1, done_k: 81, mac_cnt: 64, busy_cnt: 81, rv_cnt: 4};
    scens[1] = '{id: 5, done_k: 81, mac_cnt: 64, busy_cnt: 81, rv_cnt: 4};
    scens[2] = '{id: 2, done_k: 86, mac_cnt: 64, busy_cnt: 86, rv_cnt: 4};
    scens[3] = '{id: 3, done_k: 84, mac_cnt: 64, busy_cnt: 84, rv_cnt: 7};
    scens[4] = '{id: 4, done_k: -1, mac_cnt: 25, busy_cnt: 30, rv_cnt: 1};
    scens[5] = '{id: 1, done_k: 81, mac_cnt: 64, busy_cnt: 81, rv_cnt: 4};

    // Small instance, start held: {busy,done,res_valid,acc_clr,mac_en,x,w}
    s_exp[1] = 7'b1001000;  // CLEAR
    s_exp[2] = 7'b1000100;  // ISSUE col 0
    s_exp[3] = 7'b1000111;  // ISSUE col 1
    s_exp[4] = 7'b1000000;  // DRAIN
    s_exp[5] = 7'b1010000;  // WRITE
    s_exp[6] = 7'b1100000;  // DONE
    s_exp[7] = 7'b0000000;  // IDLE, start sampled here
    s_exp[8] = 7'b1001000;  // CLEAR of the next timestep
    s_exp[9] = 7'b1000100;  // ISSUE col 0

    reset       = 1'b1;
    start       = 1'b0;
    src_valid   = 1'b1;
    res_ready   = 1'b1;
    s_start     = 1'b0;
    s_src_valid = 1'b1;
    s_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(pack_dut()), 32'd0);
    chk("reset_outputs_small",
        32'({s_busy, s_done, s_res_valid, s_res_gate, s_acc_clr, s_mac_en, s_x_addr, s_w_addr}),
        32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_scen(scens[i]);
    end

    // Small instance with start held high through two timesteps
    s_start = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      #1;
      if (k >= 1) begin
        chk($sformatf("small_cyc%0d", k),
            32'({s_busy, s_done, s_res_valid, s_acc_clr, s_mac_en, s_x_addr, s_w_addr}),
            32'(s_exp[k]));
        if (k == 5) chk("small_res_gate", 32'(s_res_gate), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    s_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("small_back_idle", 32'(s_busy), 32'd0);
    $display("small instance: start-held sequence checked over 9 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
